// File: rtl/trace_plotter.sv
// trace_plotter: samples CHANNELS inputs into a DEPTH-entry RAM and draws them as stacked VGA lanes.
// Optional: define TRACE_PLOTTER_TRIGGER_EN to hold capture in ARMED until a rising edge on channelsIn[0].
module trace_plotter #(
  parameter int CHANNELS       = 4,
  parameter int ADDR_WIDTH     = 9,
  parameter int PRESCALE_WIDTH = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      continuous,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [CHANNELS-1:0]       channelsIn,
  input  logic [9:0]                vgaX,
  input  logic [9:0]                vgaY,
  input  logic                      vgaHsync,
  input  logic                      vgaVsync,
  input  logic                      vgaBlank,
  output logic                      r,
  output logic                      g,
  output logic                      b,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      busy,
  output logic                      full
);
  // state   | meaning
  // IDLE    | nothing being captured; trace empty or left from an aborted run
  // ARMED   | waiting for a rising edge on channelsIn[0] (trigger build only)
  // CAPTURE | writing one sample every prescale+1 clocks
  // DONE    | single-shot buffer filled, writes stopped
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef TRACE_PLOTTER_TRIGGER_EN
    ARMED   = 2'd1,
`endif
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

`ifdef TRACE_PLOTTER_TRIGGER_EN
  localparam state_t START_STATE = ARMED;
`else
  localparam state_t START_STATE = CAPTURE;
`endif

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     write_ptr;
  logic [ADDR_WIDTH:0]       count;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] div;
  logic                      cont_q;
  logic                      trig;
  logic                      sampling;
  logic                      wr_en;

  logic [CHANNELS-1:0]       mem [DEPTH];
  logic [CHANNELS-1:0]       rd_word;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [ADDR_WIDTH:0]       disp_count;
  logic [ADDR_WIDTH-1:0]     disp_base;

  logic [10:0]               x_ext;
  logic [2:0]                lane;
  logic [5:0]                row;
  logic                      col_ok;
  logic                      lane_ok;
  logic                      row_ok;
  logic                      vis1;
  logic                      vis2;
  logic [2:0]                lane2;
  logic                      hs2;
  logic                      vs2;
  logic [7:0]                pix_word;
  logic                      pix_bit;
  logic                      unused_y;

`ifdef TRACE_PLOTTER_TRIGGER_EN
  logic ch0_q;
  always_ff @(posedge clk) begin
    if (reset) ch0_q <= 1'b0;
    else       ch0_q <= channelsIn[0];
  end
  // The edge sample itself is written, so the trigger cycle counts as the first capture cycle.
  assign trig = (state == ARMED) && !ch0_q && channelsIn[0];
`else
  assign trig = 1'b0;
`endif

  assign sampling = (state == CAPTURE) || trig;
  assign wr_en    = sampling && (div == '0) && !reset && !clear && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      write_ptr  <= '0;
      count      <= '0;
      full       <= 1'b0;
      busy       <= 1'b0;
      div        <= '0;
      prescale_q <= '0;
      cont_q     <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      full  <= 1'b0;
      busy  <= 1'b0;
    end else if (start) begin
      state      <= START_STATE;
      busy       <= 1'b1;
      write_ptr  <= '0;
      count      <= '0;
      full       <= 1'b0;
      div        <= '0;
      prescale_q <= prescale;
      cont_q     <= continuous;
    end else begin
      if (trig) state <= CAPTURE;
      if (sampling) div <= (div == prescale_q) ? '0 : div + 1'b1;
      if (wr_en) begin
        write_ptr <= write_ptr + 1'b1;
        if (count != COUNT_FULL) count <= count + 1'b1;
        if (count == COUNT_LAST) begin
          full <= 1'b1;
          if (!cont_q) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

  // Read-during-write of the same address returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[write_ptr] <= channelsIn;
    rd_word <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_count <= '0;
      disp_base  <= '0;
    end else if (vgaVsync) begin
      disp_count <= count;
      disp_base  <= (cont_q && full) ? write_ptr : '0;
    end
  end

  assign rd_addr  = disp_base + vgaX[ADDR_WIDTH-1:0];
  assign x_ext    = {1'b0, vgaX};
  assign lane     = vgaY[8:6];
  assign row      = vgaY[5:0];
  assign col_ok   = (x_ext < 11'(DEPTH)) && (x_ext < 11'(disp_count));
  assign lane_ok  = {1'b0, lane} < 4'(CHANNELS);
  assign row_ok   = (row >= 6'd8) && (row <= 6'd55);
  assign vis1     = !vgaBlank && col_ok && lane_ok && row_ok;
  assign pix_word = 8'(rd_word);
  assign pix_bit  = pix_word[lane2];
  assign unused_y = vgaY[9];

  always_ff @(posedge clk) begin
    if (reset) begin
      vis2  <= 1'b0;
      lane2 <= '0;
      hs2   <= 1'b0;
      vs2   <= 1'b0;
      r     <= 1'b0;
      g     <= 1'b0;
      b     <= 1'b0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      vis2  <= vis1;
      lane2 <= lane;
      hs2   <= vgaHsync;
      vs2   <= vgaVsync;
      r     <= vis2 && !pix_bit;
      g     <= vis2 && pix_bit;
      b     <= 1'b0;
      hsync <= hs2;
      vsync <= vs2;
    end
  end

endmodule

// File: tb/tb_trace_plotter.sv
// Self-checking bench for trace_plotter (ADDR_WIDTH=6, 4 channels); video checked through an expected-pixel queue.
module tb_trace_plotter;
  localparam int CH    = 4;
  localparam int AW    = 6;
  localparam int PW    = 15;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset, start, clear, continuous;
  logic [PW-1:0] prescale;
  logic [CH-1:0] channelsIn;
  logic [9:0]    vgaX, vgaY;
  logic          vgaHsync, vgaVsync, vgaBlank;
  logic          r, g, b, hsync, vsync, busy, full;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ndisp = 0;
  int exp_first = 0;

  typedef struct {
    int x;
    int y;
    bit blank;
    bit hs;
    bit vs;
  } pix_t;
  pix_t pix_q[$];

  trace_plotter #(.CHANNELS(CH), .ADDR_WIDTH(AW), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .continuous(continuous),
    .prescale(prescale), .channelsIn(channelsIn), .vgaX(vgaX), .vgaY(vgaY),
    .vgaHsync(vgaHsync), .vgaVsync(vgaVsync), .vgaBlank(vgaBlank),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .busy(busy), .full(full)
  );

  always #5 clk = ~clk;

  // Sample n of any capture carries the value n mod 16 (see cap_step).
  function automatic logic [4:0] exp_video(input pix_t p);
    int lane = (p.y >> 6) & 7;
    int row  = p.y & 63;
    int v;
    logic [2:0] rgb = 3'b000;
    if (!p.blank && p.x < DEPTH && p.x < exp_ndisp && lane < CH && row >= 8 && row <= 55) begin
      v = (exp_first + p.x) % 16;
      rgb = (((v >> lane) & 1) != 0) ? 3'b010 : 3'b100;
    end
    return {rgb, p.hs, p.vs};
  endfunction

  task automatic set_window(input int nsamp, input bit cont);
    exp_ndisp = (nsamp > DEPTH) ? DEPTH : nsamp;
    exp_first = (cont && nsamp >= DEPTH) ? nsamp - DEPTH : 0;
  endtask

  task automatic add_pix(input int x, input int y, input bit blank, input bit hs, input bit vs);
    pix_t p;
    p.x = x; p.y = y; p.blank = blank; p.hs = hs; p.vs = vs;
    pix_q.push_back(p);
  endtask

  task automatic frame_start();
    add_pix(0, 0, 1, 0, 1);
    add_pix(0, 0, 1, 0, 1);
  endtask

  task automatic run_frame(input string tag);
    logic [4:0] exp_q[$];
    logic [4:0] e, got;
    int n = pix_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 2 || (i >= n && exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        got = {r, g, b, hsync, vsync};
        n_checks++;
        if (got !== e) $display("FAIL %s pixel#%0d rgbhv got=%b exp=%b", tag, i - 2, got, e);
        else n_pass++;
      end
      if (i < n) begin
        vgaX = 10'(pix_q[i].x);
        vgaY = 10'(pix_q[i].y);
        vgaBlank = pix_q[i].blank;
        vgaHsync = pix_q[i].hs;
        vgaVsync = pix_q[i].vs;
        exp_q.push_back(exp_video(pix_q[i]));
      end
    end
    pix_q.delete();
    vgaBlank = 1'b1; vgaHsync = 1'b0; vgaVsync = 1'b0; vgaX = '0; vgaY = '0;
  endtask

  // Leaves the bench just after the edge that samples start (edge 0).
  task automatic do_start(input bit cont, input int p);
    @(posedge clk); #1;
    start = 1'b1; continuous = cont; prescale = PW'(p); channelsIn = '0;
    @(posedge clk); #1;
    start = 1'b0; channelsIn = '0;
  endtask

  // After edge k, drive value k/(p+1): the write at edge 1+j*(p+1) then stores j.
  task automatic cap_step(input int k, input int p);
    @(posedge clk); #1;
    channelsIn = 4'((k / (p + 1)) & 15);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({r, g, b, hsync, vsync} !== 5'b0) $display("FAIL reset_video got=%b exp=00000", {r, g, b, hsync, vsync}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    n_checks++; if (dut.count !== 7'd0) $display("FAIL reset_count got=%0d exp=0", dut.count); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_pipeline();
    @(posedge clk); #1; vgaHsync = 1'b1;
    @(posedge clk); #1; vgaHsync = 1'b0;
    n_checks++; if (hsync !== 1'b0) $display("FAIL pipe_hsync_d1 got=%b exp=0", hsync); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (hsync !== 1'b1) $display("FAIL pipe_hsync_d2 got=%b exp=1", hsync); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (hsync !== 1'b0) $display("FAIL pipe_hsync_d3 got=%b exp=0", hsync); else n_pass++;
  endtask

  task automatic test_single_shot();
    int rows[4] = '{7, 8, 55, 56};
    do_start(1'b0, 0);
    for (int k = 1; k <= 66; k++) begin
      cap_step(k, 0);
      n_checks++; if (full !== 1'(k >= DEPTH)) $display("FAIL single_full k=%0d got=%b exp=%b", k, full, k >= DEPTH); else n_pass++;
      n_checks++; if (busy !== 1'(k < DEPTH)) $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, k < DEPTH); else n_pass++;
    end
    n_checks++; if (dut.count !== 7'd64) $display("FAIL single_count got=%0d exp=64", dut.count); else n_pass++;
    set_window(64, 1'b0);
    frame_start();
    for (int l = 0; l < 5; l++)
      for (int c = 0; c < 67; c++) add_pix(c, l * 64 + 20, 0, 0, 0);
    for (int l = 0; l < 4; l++)
      foreach (rows[i]) add_pix(3, l * 64 + rows[i], 0, 0, 0);
    add_pix(3, 84, 1, 1, 0);
    add_pix(9, 20, 1, 0, 0);
    add_pix(5, 20, 0, 1, 0);
    run_frame("single");
  endtask

  task automatic test_prescale_clear();
    do_start(1'b0, 3);
    for (int k = 1; k <= 37; k++) begin
      cap_step(k, 3);
      n_checks++; if (dut.count !== 7'((k - 1) / 4 + 1)) $display("FAIL pre3_count k=%0d got=%0d exp=%0d", k, dut.count, (k - 1) / 4 + 1); else n_pass++;
    end
    pulse_clear();
    n_checks++; if (busy !== 1'b0) $display("FAIL pre3_clear_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (dut.count !== 7'd0) $display("FAIL pre3_clear_count got=%0d exp=0", dut.count); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL pre3_clear_full got=%b exp=0", full); else n_pass++;
    set_window(0, 1'b0);
    frame_start();
    for (int l = 0; l < 4; l++) begin
      add_pix(0, l * 64 + 20, 0, 0, 0);
      add_pix(5, l * 64 + 20, 0, 0, 0);
      add_pix(9, l * 64 + 30, 0, 0, 0);
    end
    run_frame("cleared");
  endtask

  task automatic test_continuous_wrap();
    do_start(1'b1, 99);
    for (int k = 1; k <= 6801; k++) begin
      cap_step(k, 99);
      if (k == 6300) begin
        n_checks++; if (full !== 1'b0) $display("FAIL wrap_full_early got=%b exp=0", full); else n_pass++;
      end
      if (k == 6301) begin
        n_checks++; if (full !== 1'b1) $display("FAIL wrap_full_rise got=%b exp=1", full); else n_pass++;
      end
      if (k % 500 == 1) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL wrap_busy k=%0d got=%b exp=1", k, busy); else n_pass++;
      end
    end
    n_checks++; if (dut.count !== 7'd64) $display("FAIL wrap_count_sat got=%0d exp=64", dut.count); else n_pass++;
    set_window(69, 1'b1);
    frame_start();
    for (int c = 0; c < 64; c++) add_pix(c, 20, 0, 0, 0);
    for (int l = 1; l < 4; l++) begin
      add_pix(0, l * 64 + 20, 0, 0, 0);
      add_pix(63, l * 64 + 20, 0, 0, 0);
    end
    run_frame("wrap");
    n_checks++; if (busy !== 1'b1) $display("FAIL wrap_busy_end got=%b exp=1", busy); else n_pass++;
    n_checks++; if (full !== 1'b1) $display("FAIL wrap_full_end got=%b exp=1", full); else n_pass++;
    pulse_clear();
  endtask

  task automatic test_start_clear();
    do_start(1'b0, 0);
    for (int k = 1; k <= 3; k++) cap_step(k, 0);
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL sc_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (dut.count !== 7'd0) $display("FAIL sc_count got=%0d exp=0", dut.count); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dut.count !== 7'd0) $display("FAIL sc_count_later got=%0d exp=0", dut.count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL sc_busy_later got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_trigger();
`ifdef TRACE_PLOTTER_TRIGGER_EN
    do_start(1'b0, 0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      channelsIn = '0;
      if (k % 25 == 0) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL trig_busy k=%0d got=%b exp=1", k, busy); else n_pass++;
        n_checks++; if (dut.count !== 7'd0) $display("FAIL trig_nowrite k=%0d got=%0d exp=0", k, dut.count); else n_pass++;
      end
    end
    channelsIn = 4'b0101;
    @(posedge clk); #1;
    n_checks++; if (dut.count !== 7'd1) $display("FAIL trig_first_count got=%0d exp=1", dut.count); else n_pass++;
    n_checks++; if (dut.mem[0][0] !== 1'b1) $display("FAIL trig_first_bit0 got=%b exp=1", dut.mem[0][0]); else n_pass++;
    pulse_clear();
`endif
  endtask

  task automatic test_reset_mid_capture();
    do_start(1'b1, 0);
    vgaHsync = 1'b1; vgaVsync = 1'b1; vgaBlank = 1'b0; vgaX = 10'd1; vgaY = 10'd20;
    for (int k = 1; k <= 5; k++) cap_step(k, 0);
    n_checks++; if (hsync !== 1'b1) $display("FAIL rst_pre_hsync got=%b exp=1", hsync); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got=%b exp=1", busy); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({r, g, b, hsync, vsync} !== 5'b0) $display("FAIL rst_mid_video got=%b exp=00000", {r, g, b, hsync, vsync}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rst_mid_full got=%b exp=0", full); else n_pass++;
    n_checks++; if (dut.count !== 7'd0) $display("FAIL rst_mid_count got=%0d exp=0", dut.count); else n_pass++;
    reset = 1'b0;
    vgaHsync = 1'b0; vgaVsync = 1'b0; vgaBlank = 1'b1; vgaX = '0; vgaY = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear = 1'b0; continuous = 1'b0; prescale = '0;
    channelsIn = '0; vgaX = '0; vgaY = '0; vgaHsync = 1'b0; vgaVsync = 1'b0; vgaBlank = 1'b1;
    test_reset();
    test_pipeline();
    test_single_shot();
    test_prescale_clear();
    test_continuous_wrap();
    test_start_clear();
    test_trigger();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_plotter.md
# trace_plotter

Multi-channel successor of the single-bit plotter: samples `CHANNELS` logic inputs at a programmable rate into on-chip dual-port RAM, and renders them as stacked lanes on the VGA output. The block sits between the VGA timing generator, whose stage-1 outputs feed it, and the colour/sync output pins. It adds arm/trigger control, single-shot or continuous (wrapping) capture, and frame-consistent display of the captured window.

## Interface
- `CHANNELS`, 4: number of sampled inputs and display lanes; legal range 1..8.
- `ADDR_WIDTH`, 9: sample depth `DEPTH = 2**ADDR_WIDTH`, one sample per pixel column; legal range 6..10.
- `PRESCALE_WIDTH`, 15: width of the sample-rate divider.

- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that arms a new capture.
- `clear` in 1: single-cycle pulse that aborts capture and empties the trace.
- `continuous` in 1: 0 = single-shot, 1 = wrap. Latched on `start`.
- `prescale` in PRESCALE_WIDTH: one sample every `prescale+1` clocks. Latched on `start`.
- `channelsIn` in CHANNELS: sampled inputs, already synchronous to `clk`.
- `vgaX`, `vgaY` in 10 each: stage-1 pixel coordinates.
- `vgaHsync`, `vgaVsync`, `vgaBlank` in 1 each: stage-1 sync and blank signals.
- `r`, `g`, `b`, `hsync`, `vsync` out 1 each: stage-3 registered video outputs.
- `busy` out 1: high in ARMED or CAPTURE.
- `full` out 1: high once `DEPTH` samples have been written since the last `start`.

## Operation
- States: IDLE, ARMED (exists only with `TRIGGER_EN`), CAPTURE, DONE.
- **Reset.** State IDLE; `writePtr`=0; `count`=0; all outputs 0. RAM contents are not reset.
- **Start.** `start` from any state: `writePtr`=0, `count`=0, `full`=0, latch `continuous` and `prescale`. Next state is ARMED (with `TRIGGER_EN`) or CAPTURE.
- **Clear.** `clear` from any state: IDLE, `count`=0, `full`=0. When `clear` and `start` are high together, `clear` wins. `reset` wins over both.
- **Prescale.** On entering CAPTURE the divider is set to 0. A write occurs on every CAPTURE cycle where the divider is 0; the divider counts 0..`prescale` and then wraps. The first sample is written on the first CAPTURE cycle.
- **Write.** Each write stores `channelsIn` at `writePtr`. `writePtr` then increments modulo DEPTH, and `count` increments, saturating at DEPTH (ADDR_WIDTH+1 bits).
- **Single-shot.** The DEPTH-th write sets `full`=1 and moves to DONE. No further writes occur.
- **Continuous.** `writePtr` wraps. `full`=1 from the DEPTH-th write onward. The state stays CAPTURE until `start` or `clear`.
- **Display snapshot.** `dispCount` and `dispBase` are loaded while `vgaVsync` is asserted, so each frame shows a stable window:
  - `dispCount` = `count`.
  - `dispBase` = `writePtr` if continuous and full, else 0.
- **Column mapping.** Column `c` = `vgaX` is valid when `vgaX` < DEPTH and `c` < `dispCount`. Read address = `dispBase + c` mod DEPTH, so the display is oldest-first.
- **Lane mapping.**
  - Lane = `vgaY[8:6]`; it is valid when lane < CHANNELS.
  - Row-in-lane = `vgaY[5:0]`; it is visible for rows 8..55 and black otherwise.
- **Pixel colour.** A visible pixel with bit=1 drives `g`=1, `r`=0. A visible pixel with bit=0 drives `r`=1, `g`=0. `b` is always 0. Every other pixel, including blank, is black.

## Timing
- Video latency is 2 clocks: stage-1 inputs → RAM read / registered stage 2 → output registers at stage 3. `hsync` and `vsync` are delayed identically, with polarity passed through.
- A RAM write and a read of the same address in the same cycle return the old data. This is acceptable.
- `busy` and `full` are registered and change in the cycle after the causing event.
- A `start` in the same cycle as a pending write aborts that write.
- Maximum sample rate is one per clock (`prescale`=0).

## Configuration
- `TRACE_PLOTTER_TRIGGER_EN` defined:
  - ARMED state is present.
  - A rising edge of `channelsIn[0]` (registered copy 0, current 1) moves ARMED to CAPTURE.
  - The sample carrying the edge is the first sample written.
- Not defined:
  - ARMED is absent.
  - `start` enters CAPTURE directly.
  - `channelsIn[0]` is an ordinary channel.

## Test plan
- **Single-shot, prescale 0.** Setup: ADDR_WIDTH=6, `prescale`=0, counting pattern on `channelsIn`. Pulse `start`.
  - `full` rises 64 cycles after CAPTURE entry; state DONE.
  - Next frame shows column c as the lane bits of value c; columns ≥64 are black.
- **Prescale 3, cleared mid-capture.** Pulse `clear` after 10 samples.
  - Writes occur exactly every 4 clocks.
  - After `clear`, `busy`=0, `count`=0, and the next frame is fully black.
- **Continuous wrap.** Capture 64+5 samples.
  - `full`=1 and `busy` stays 1.
  - Column 0 displays sample 5; column 63 displays sample 68.
- **Simultaneous and reset cases.**
  - `start` and `clear` in the same cycle → IDLE.
  - `reset` asserted mid-CAPTURE → all outputs 0 and `count`=0 on the next edge.
- **Trigger (with `TRIGGER_EN`).** Hold `channelsIn[0]`=0 for 100 clocks after `start`, then raise it.
  - `busy` stays 1 with no writes while ARMED.
  - The first written sample has bit0=1.
- **Pipeline alignment.** A `vgaHsync` pulse appears on `hsync` exactly 2 clocks later. With `vgaBlank`=1, `r`=`g`=`b`=0.
